// File: rtl/gcd_arb_pkg.sv
// Shared types and constants for the gcd_ci engine arbiter.
package gcd_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        START,
        WAIT,
        RESP
    } state_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gcd_ci_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer (wrapping) and reports it both one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    localparam int SUM_W = IW + 1;

    logic [SUM_W-1:0] sum;
    logic [IW-1:0]    cand;

    // Scan requesters starting from the pointer and take the first one found.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(N)) begin
                sum = sum - SUM_W'(N);
            end
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/gcd_ci_arbiter.sv
// Shares one gcd_ci engine among NUM_REQ requesters with round-robin
// arbitration. One request is in flight at a time: operands are latched on
// accept, written to the engine, started, and the result is held on the
// response channel until consumed.
// Optional feature: define GCD_ARB_TIMEOUT_EN to add an engine watchdog that
// abandons an operation after TIMEOUT_CYCLES cycles in WAIT and returns an
// error response with zero data.
module gcd_ci_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    csi_clk,
    input  logic                    rsi_reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_error,
    output logic                    eng_clk_en,
    output logic                    eng_s0_write,
    output logic                    eng_s1_write,
    output logic                    eng_s2_read,
    output logic [31:0]             eng_s0_writedata,
    output logic [31:0]             eng_s1_writedata,
    output logic                    eng_start,
    input  logic                    eng_done,
    input  logic [31:0]             eng_s2_readdata
);

    state_t               state;
    logic [IDW-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_any;
    logic [DATA_W-1:0]    sel_a;
    logic [DATA_W-1:0]    sel_b;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]     wait_cnt;
    logic                 rsp_error_q;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (grant_idx),
        .any   (grant_any)
    );

    // Pick the granted requester's operands out of the packed buses.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Accept is combinational so the requester sees it in the same cycle it is granted.
    assign req_ready   = (state == IDLE) ? grant : '0;
    assign eng_s2_read = (state == WAIT) && eng_done;

`ifdef GCD_ARB_TIMEOUT_EN
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    // Sequencer: arbitrate, write A, write B, start, wait for done, hand back the result.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            rsp_id           <= '0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            eng_s0_writedata <= '0;
            eng_s1_writedata <= '0;
            eng_s0_write     <= 1'b0;
            eng_s1_write     <= 1'b0;
            eng_start        <= 1'b0;
            eng_clk_en       <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            wait_cnt         <= '0;
            rsp_error_q      <= 1'b0;
`endif
        end else begin
            eng_s0_write <= 1'b0;
            eng_s1_write <= 1'b0;
            eng_start    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        eng_s0_writedata <= sel_a;
                        eng_s1_writedata <= sel_b;
                        rsp_id           <= grant_idx;
                        rr_ptr           <= IDW'(wrap_next(32'(grant_idx), NUM_REQ));
                        eng_s0_write     <= 1'b1;
                        eng_clk_en       <= 1'b1;
                        state            <= WR_A;
                    end
                end
                WR_A: begin
                    eng_s1_write <= 1'b1;
                    state        <= WR_B;
                end
                WR_B: begin
                    eng_start <= 1'b1;
                    state     <= START;
                end
                START: begin
`ifdef GCD_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        rsp_data  <= eng_s2_readdata;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef GCD_ARB_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data    <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_error_q <= 1'b1;
                        eng_clk_en  <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        eng_clk_en <= 1'b0;
                        state      <= IDLE;
`ifdef GCD_ARB_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
`endif
                    end else begin
                        eng_clk_en <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_ci_arbiter.sv
// Self-checking bench for gcd_ci_arbiter: behavioural GCD engine, table of
// single-request vectors, and hand-written sequences for fairness,
// back-pressure, spurious done, dropped requests, reset abort and timeout.
module tb_gcd_ci_arbiter;

    localparam int NR = 4;

    logic            csi_clk = 1'b0;
    logic            rsi_reset_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_a = '0;
    logic [NR*32-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_error;
    logic            eng_clk_en;
    logic            eng_s0_write;
    logic            eng_s1_write;
    logic            eng_s2_read;
    logic [31:0]     eng_s0_writedata;
    logic [31:0]     eng_s1_writedata;
    logic            eng_start;
    logic            eng_done;
    logic [31:0]     eng_s2_readdata;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    logic        spurious_done = 1'b0;
    logic        eng_hang = 1'b0;
    int          eng_latency = 4;
    logic [31:0] eng_a_m = '0;
    logic [31:0] eng_b_m = '0;
    logic [31:0] eng_rd_m = '0;
    logic        eng_done_m = 1'b0;
    logic        eng_busy_m = 1'b0;
    int          eng_cnt_m = 0;

    assign eng_done        = eng_done_m | spurious_done;
    assign eng_s2_readdata = eng_rd_m;

    gcd_ci_arbiter #(
        .NUM_REQ        (NR),
        .IDW            (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .csi_clk          (csi_clk),
        .rsi_reset_n      (rsi_reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_id           (rsp_id),
        .rsp_error        (rsp_error),
        .eng_clk_en       (eng_clk_en),
        .eng_s0_write     (eng_s0_write),
        .eng_s1_write     (eng_s1_write),
        .eng_s2_read      (eng_s2_read),
        .eng_s0_writedata (eng_s0_writedata),
        .eng_s1_writedata (eng_s1_writedata),
        .eng_start        (eng_start),
        .eng_done         (eng_done),
        .eng_s2_readdata  (eng_s2_readdata)
    );

    always #5 csi_clk = ~csi_clk;

    function automatic logic [31:0] gcdRef(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p;
        logic [31:0] q;
        logic [31:0] t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s (t=%0t)", name, $time);
    endtask

    // Behavioural engine: latches operands, answers gcd a few cycles after start.
    always @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            eng_busy_m <= 1'b0;
            eng_done_m <= 1'b0;
            eng_cnt_m  <= 0;
        end else begin
            eng_done_m <= 1'b0;
            if (eng_s0_write) eng_a_m <= eng_s0_writedata;
            if (eng_s1_write) eng_b_m <= eng_s1_writedata;
            if (eng_start) begin
                eng_busy_m <= 1'b1;
                eng_cnt_m  <= eng_latency;
            end else if (eng_busy_m) begin
                if (eng_cnt_m <= 1) begin
                    eng_busy_m <= 1'b0;
                    if (!eng_hang) begin
                        eng_done_m <= 1'b1;
                        eng_rd_m   <= gcdRef(eng_a_m, eng_b_m);
                    end
                end else begin
                    eng_cnt_m <= eng_cnt_m - 1;
                end
            end
        end
    end

    // Monitor on the falling edge: grants, engine writes, start latency, responses.
    always @(negedge csi_clk) begin
        logic [NR-1:0] exp_oh;
        sb_t           e;
        cyc++;
        if (rsi_reset_n) begin
            if (|(req_ready & req_valid)) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_grant");
                end else begin
                    exp_oh = NR'(1) << sb[0].id;
                    checkOutput("grant_onehot", 32'(req_ready), 32'(exp_oh));
                    accept_cyc = cyc;
                end
            end
            if (eng_s0_write && sb.size() > 0) checkOutput("eng_wr_a", eng_s0_writedata, sb[0].a);
            if (eng_s1_write && sb.size() > 0) checkOutput("eng_wr_b", eng_s1_writedata, sb[0].b);
            if (eng_start) begin
                checkOutput("start_latency", 32'(cyc - accept_cyc), 32'd3);
                checkOutput("clk_en_busy", 32'(eng_clk_en), 32'd1);
            end
            if (eng_done_m) checkOutput("s2_read_on_done", 32'(eng_s2_read), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_response");
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_error", 32'(rsp_error), 32'(e.err));
                end
            end
        end
    end

    task automatic pushExp(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] data, input logic err);
        sb_t e;
        e.id = id; e.a = a; e.b = b; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic driveReq(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_valid[id]      = 1'b1;
    endtask

    task automatic waitAccept(input int id);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge csi_clk);
            if (req_ready[id]) ok = 1'b1;
            else n++;
        end
        if (!ok) failNow("accept_timeout");
        @(posedge csi_clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] data, input logic err);
        pushExp(id, a, b, data, err);
        @(posedge csi_clk); #1;
        driveReq(id, a, b);
        waitAccept(id);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge csi_clk);
            n++;
        end
        if (sb.size() > 0) begin
            failNow("drain_timeout");
            sb.delete();
        end
        @(posedge csi_clk); #1;
        @(posedge csi_clk); #1;
    endtask

    task automatic waitSignal(input string name, input int which, input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge csi_clk);
            seen = (which == 0) ? eng_start : rsp_valid;
            n++;
        end
        if (!seen) failNow(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int grants;
        int n;
        vecs[0] = '{id: 0, a: 32'd48,   b: 32'd18,  exp: 32'd6};
        vecs[1] = '{id: 1, a: 32'd100,  b: 32'd75,  exp: 32'd25};
        vecs[2] = '{id: 2, a: 32'd17,   b: 32'd5,   exp: 32'd1};
        vecs[3] = '{id: 3, a: 32'd0,    b: 32'd9,   exp: 32'd9};
        vecs[4] = '{id: 1, a: 32'd270,  b: 32'd192, exp: 32'd6};
        vecs[5] = '{id: 3, a: 32'd1071, b: 32'd462, exp: 32'd21};

        // reset state
        repeat (3) @(negedge csi_clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_eng_clk_en", 32'(eng_clk_en), 32'd0);
        checkOutput("rst_eng_start", 32'(eng_start), 32'd0);
        checkOutput("rst_eng_wdata", eng_s0_writedata, 32'd0);
        @(posedge csi_clk); #1;
        rsi_reset_n = 1'b1;

        // single requests from the table
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
            waitDrain(300);
        end
        @(negedge csi_clk);
        checkOutput("idle_clk_en", 32'(eng_clk_en), 32'd0);

        // all four held valid from pointer 0: order 0,1,2,3,0
        pushExp(0, 32'd60, 32'd48, 32'd12, 1'b0);
        pushExp(1, 32'd81, 32'd27, 32'd27, 1'b0);
        pushExp(2, 32'd35, 32'd14, 32'd7, 1'b0);
        pushExp(3, 32'd1000, 32'd625, 32'd125, 1'b0);
        pushExp(0, 32'd60, 32'd48, 32'd12, 1'b0);
        @(posedge csi_clk); #1;
        driveReq(0, 32'd60, 32'd48);
        driveReq(1, 32'd81, 32'd27);
        driveReq(2, 32'd35, 32'd14);
        driveReq(3, 32'd1000, 32'd625);
        grants = 0;
        n = 0;
        while (grants < 5 && n < 1000) begin
            @(negedge csi_clk);
            if (|req_ready) grants++;
            n++;
        end
        checkOutput("fair_grant_count", 32'(grants), 32'd5);
        @(posedge csi_clk); #1;
        req_valid = '0;
        waitDrain(300);

        // back-pressure: response held 20 cycles, queued request waits
        rsp_ready = 1'b0;
        applyStimulus(1, 32'd84, 32'd36, 32'd12, 1'b0);
        pushExp(2, 32'd91, 32'd65, 32'd13, 1'b0);
        driveReq(2, 32'd91, 32'd65);
        waitSignal("rsp_valid_timeout", 1, 300);
        for (int k = 0; k < 20; k++) begin
            @(negedge csi_clk);
            checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_rsp_data", rsp_data, 32'd12);
            checkOutput("stall_rsp_id", 32'(rsp_id), 32'd1);
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge csi_clk); #1;
        rsp_ready = 1'b1;
        waitAccept(2);
        waitDrain(300);

        // spurious done while idle, then req3 alone at pointer 3
        spurious_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge csi_clk);
            checkOutput("spur_s2_read", 32'(eng_s2_read), 32'd0);
            checkOutput("spur_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("spur_clk_en", 32'(eng_clk_en), 32'd0);
        end
        @(posedge csi_clk); #1;
        spurious_done = 1'b0;
        applyStimulus(3, 32'd12, 32'd8, 32'd4, 1'b0);
        waitDrain(300);
        pushExp(0, 32'd14, 32'd21, 32'd7, 1'b0);
        pushExp(1, 32'd13, 32'd13, 32'd13, 1'b0);
        @(posedge csi_clk); #1;
        driveReq(0, 32'd14, 32'd21);
        driveReq(1, 32'd13, 32'd13);
        waitAccept(0);
        waitAccept(1);
        waitDrain(300);

        // request withdrawn while busy must never be granted
        applyStimulus(0, 32'd9, 32'd6, 32'd3, 1'b0);
        driveReq(2, 32'd5, 32'd5);
        @(posedge csi_clk); #1;
        @(posedge csi_clk); #1;
        req_valid[2] = 1'b0;
        waitDrain(300);
        for (int k = 0; k < 5; k++) begin
            @(negedge csi_clk);
            checkOutput("dropped_req_ready", 32'(req_ready), 32'd0);
        end

        // reset while waiting on the engine aborts without a response
        eng_latency = 30;
        applyStimulus(1, 32'd50, 32'd20, 32'd10, 1'b0);
        waitSignal("start_timeout", 0, 50);
        repeat (3) @(negedge csi_clk);
        #2;
        rsi_reset_n = 1'b0;
        #1;
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_rsp_data", rsp_data, 32'd0);
        checkOutput("abort_clk_en", 32'(eng_clk_en), 32'd0);
        checkOutput("abort_wdata_b", eng_s1_writedata, 32'd0);
        checkOutput("abort_rsp_id", 32'(rsp_id), 32'd0);
        sb.delete();
        @(posedge csi_clk); #1;
        rsi_reset_n = 1'b1;
        eng_latency = 4;
        pushExp(0, 32'd45, 32'd30, 32'd15, 1'b0);
        pushExp(2, 32'd8, 32'd12, 32'd4, 1'b0);
        driveReq(0, 32'd45, 32'd30);
        driveReq(2, 32'd8, 32'd12);
        waitAccept(0);
        waitAccept(2);
        waitDrain(300);

`ifdef GCD_ARB_TIMEOUT_EN
        // engine never finishes: watchdog returns an error after 16 WAIT cycles
        eng_hang = 1'b1;
        applyStimulus(3, 32'd7, 32'd7, 32'd0, 1'b1);
        waitSignal("start_timeout", 0, 50);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge csi_clk);
            n++;
        end
        checkOutput("timeout_wait_cycles", 32'(n - 1), 32'd16);
        checkOutput("timeout_clk_en_drop", 32'(eng_clk_en), 32'd0);
        waitDrain(100);
        eng_hang = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
